// File: rtl/signal_frame_loader_pkg.sv
// Shared constants for the padded-signal bus between the frame loader and the
// receptive-field selector, plus the loader's two-state encoding.
package signal_frame_loader_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int W          = 1024;
    localparam int P          = 28;
    localparam int CNT_W      = 11;
    localparam int SIG_W      = (W + 2 * P) * DATA_WIDTH;

    typedef enum logic {
        LOAD = 1'b0,
        FULL = 1'b1
    } state_t;

endpackage

// File: rtl/signal_frame_loader.sv
// Serial-to-parallel frame loader: writes W streamed samples into the data
// region of a zero-padded bus and holds the frame until frame_ack.
module signal_frame_loader
    import signal_frame_loader_pkg::*;
#(
    parameter int DATA_WIDTH = signal_frame_loader_pkg::DATA_WIDTH,
    parameter int W          = signal_frame_loader_pkg::W,
    parameter int P          = signal_frame_loader_pkg::P,
    parameter int CNT_W      = signal_frame_loader_pkg::CNT_W
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                s_valid,
    input  logic [DATA_WIDTH-1:0]               s_data,
    input  logic                                s_last,
    output logic                                s_ready,
    input  logic                                frame_ack,
    output logic [0:(W+2*P)*DATA_WIDTH-1]       signal,
    output logic                                frame_valid,
    output logic                                frame_err,
    output logic [CNT_W-1:0]                    sample_count
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(W - 1);

    state_t                      state_reg, state_next;
    logic [CNT_W-1:0]            count_reg, count_next;
    logic                        err_reg, err_next;
    logic                        xfer;
    logic [0:W*DATA_WIDTH-1]     data_reg;

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        err_next   = 1'b0;
        xfer       = s_valid && (state_reg == LOAD);

        if (state_reg == FULL) begin
            if (frame_ack) begin
                state_next = LOAD;
            end
        end else if (xfer) begin
            if (count_reg == LAST_IDX) begin
                // The W-th sample always completes the frame; a missing
                // s_last is reported but does not hold the frame back.
                state_next = FULL;
                count_next = '0;
                err_next   = !s_last;
            end else if (s_last) begin
                count_next = '0;
                err_next   = 1'b1;
            end else begin
                count_next = count_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= LOAD;
            count_reg <= '0;
            err_reg   <= 1'b0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            err_reg   <= err_next;
            if (xfer) begin
                data_reg[int'(count_reg) * DATA_WIDTH +: DATA_WIDTH] <= s_data;
            end
        end
    end

    assign s_ready      = (state_reg == LOAD);
    assign frame_valid  = (state_reg == FULL);
    assign frame_err    = err_reg;
    assign sample_count = count_reg;

    // Pad slots are tied to zero and carry no storage.
    for (genvar gi = 0; gi < W + 2 * P; gi++) begin : g_slot
        if (gi < P || gi >= P + W) begin : g_pad
            assign signal[gi * DATA_WIDTH +: DATA_WIDTH] = '0;
        end else begin : g_data
            assign signal[gi * DATA_WIDTH +: DATA_WIDTH] =
                data_reg[(gi - P) * DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule

// File: doc/signal_frame_loader.md
Name: signal_frame_loader

Overview:
- Writer side of the padded-signal bus that the receptive-field selector reads.
- Accepts one vibration frame as a serial stream of W samples over a valid/ready handshake.
- Places each sample into a flat, zero-padded signal register: P zero samples, then W data samples, then P zero samples.
- Presents the completed frame on that bus with frame_valid, and holds it stable until the consumer acknowledges it.

Parameters:
- DATA_WIDTH, 16, bits per sample.
- W, 1024, samples per frame.
- P, 28, zero-pad samples on each side.
- CNT_W, 11, sample counter width; must satisfy 2^CNT_W > W.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous active-low reset.
- s_valid  input  1  input sample valid.
- s_data  input  DATA_WIDTH  input sample, two's complement.
- s_last  input  1  marks the final sample of a frame.
- s_ready  output  1  loader can accept a sample.
- frame_ack  input  1  consumer has finished with the presented frame.
- signal  output  [0:(W+2*P)*DATA_WIDTH-1]  padded frame bus; sample slot j occupies signal[j*DATA_WIDTH +: DATA_WIDTH].
- frame_valid  output  1  signal holds a complete frame.
- frame_err  output  1  one-cycle pulse on a framing error.
- sample_count  output  CNT_W  samples accepted in the current frame.

Behaviour:
- Clock and reset: single clock, clk. reset_n is synchronous and active-low, sampled only on the rising edge of clk.
- Reset (reset_n=0 at an edge): state=LOAD, sample_count=0, frame_valid=0, frame_err=0, entire signal bus = 0. Reset wins over every other input, including in the middle of a frame.
- Pad slots 0..P-1 and P+W..W+2P-1 are constant zero. They are never written.
- States:
  - LOAD: s_ready=1, frame_valid=0.
  - FULL: s_ready=0, frame_valid=1.
  - s_ready and frame_valid are decoded combinationally from state.
- Transfer: occurs when s_valid && s_ready at a clk edge. s_data is written to slot P+sample_count at that edge, and sample_count increments.
- Frame completion: a transfer with sample_count==W-1 is the final transfer. At that edge: state->FULL, sample_count->0. frame_valid=1 from the next cycle.
  - Latency: the W-th accepted sample is visible on signal, and frame_valid is high, one cycle after its transfer edge.
- s_last check:
  - s_last with sample_count==W-1: normal completion.
  - s_last with sample_count<W-1 (short frame): that sample is written, frame_err pulses for one cycle, sample_count->0, state stays LOAD. frame_valid is not raised. Stale data slots are not cleared; the next frame overwrites them fully.
  - No s_last on the W-th sample (long frame): the frame still completes into FULL and frame_err pulses for one cycle.
- FULL: signal is held bit-stable. s_valid is ignored, with no transfer and no error. When frame_ack=1: state->LOAD at that edge and s_ready=1 the next cycle. frame_ack while in LOAD has no effect.
- frame_err is registered: high exactly one cycle after the offending transfer edge, low otherwise.
- sample_count saturates logically at W-1; wrap only occurs via completion or error.
- Data slots from the previous frame persist in LOAD until overwritten. The consumer must qualify signal with frame_valid.

Decomposition:
- Shared package: DATA_WIDTH, W, P, derived SIG_W=(W+2*P)*DATA_WIDTH, and the state encoding (LOAD=1'b0, FULL=1'b1). The receptive-field selector's signal input width is taken from the same SIG_W.
- No sub-module: counter, two-state FSM and write-enable decode stay in one module.
- Slot write uses an indexed part-select on the registered data region.

Test Plan:
- Bench runs at W=16, P=4, DATA_WIDTH=16 for speed, with one scenario repeated at defaults.
- Reset mid-frame: load 5 samples, drop reset_n for 1 cycle -> signal all 0, sample_count=0, s_ready=1, frame_valid=0 the next cycle.
- Normal frame: stream 16 samples of value 0x0100+k, s_last on k=15, s_valid constant -> frame_valid=1 the cycle after the 16th transfer; slot 4+k=0x0100+k; slots 0-3 and 20-23 = 0; frame_err never asserted.
- Backpressure: in FULL, drive s_valid=1 with 0xDEAD for 10 cycles, then frame_ack for 1 cycle -> signal unchanged throughout; s_ready=1 one cycle after the ack; first new sample lands in slot 4.
- Short frame: s_last on the 7th sample -> frame_err high 1 cycle; sample_count=0; state LOAD; the next full 16-sample frame completes normally.
- Long frame: 16 samples with no s_last -> frame_valid=1 and a frame_err pulse in the same cycle.
- Gappy input: random s_valid at 30% duty at defaults (W=1024) -> exactly 1024 transfers; pads 0..27 and 1052..1079 are zero; data in order.
